// File: rtl/router_input_unit.sv
// Router input port: flit FIFO, head-flit destination extraction, and a
// per-packet route hold that forwards flits to the switch via valid/ready.
module router_input_unit #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_head,
    input  logic              in_tail,
    output logic [29:0]       dest_x,
    output logic [29:0]       dest_y,
    input  logic [2:0]        route_port,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_head,
    output logic              out_tail,
    output logic [2:0]        out_port,
    output logic              route_err,
    output logic              proto_err
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam int unsigned COORD_W = 30;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROUTE  = 2'd1,
        ACTIVE = 2'd2
    } state_e;

    state_e               state_q;
    logic [DATA_W-1:0]    mem_data_q [DEPTH];
    logic                 mem_head_q [DEPTH];
    logic                 mem_tail_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [COORD_W-1:0]   dest_x_q, dest_y_q;
    logic [2:0]           out_port_q;
    logic                 route_err_q, proto_err_q;
    logic                 first_q;

    logic                 empty, full, push, pop, drop, accept;
    logic [2:0]           route_low;
    logic                 route_multi;

    // FIFO status and handshake decode
    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CW'(DEPTH));
        in_ready  = ~full;
        push      = in_valid & ~full;
        out_data  = mem_data_q[rd_ptr_q];
        out_head  = mem_head_q[rd_ptr_q];
        out_tail  = mem_tail_q[rd_ptr_q];
        out_valid = (state_q == ACTIVE) & ~empty;
        accept    = out_valid & out_ready;
        drop      = (state_q == IDLE) & ~empty & ~out_head;
        pop       = accept | drop;
    end

    // Pointer/count next state; simultaneous push and pop keep count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)      count_d = count_q + CW'(1);
        else if (!push && pop) count_d = count_q - CW'(1);
    end

    // Isolate lowest set bit; flag any one-hot violation
    always_comb begin
        route_low   = route_port & (~route_port + 3'd1);
        route_multi = |(route_port & (route_port - 3'd1));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= in_data;
            mem_head_q[wr_ptr_q] <= in_head;
            mem_tail_q[wr_ptr_q] <= in_tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Packet framing FSM with registered route hold and error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dest_x_q    <= '0;
            dest_y_q    <= '0;
            out_port_q  <= '0;
            route_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            first_q     <= 1'b0;
        end else begin
            route_err_q <= 1'b0;
            proto_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        if (out_head) begin
                            dest_x_q <= out_data[29:0];
                            dest_y_q <= out_data[59:30];
                            state_q  <= ROUTE;
                        end else begin
                            proto_err_q <= 1'b1;
                        end
                    end
                end
                ROUTE: begin
                    out_port_q  <= route_low;
                    route_err_q <= route_multi;
                    first_q     <= 1'b1;
                    state_q     <= ACTIVE;
                end
                ACTIVE: begin
                    if (accept) begin
                        first_q <= 1'b0;
                        // A fresh head inside a packet is forwarded but flagged
                        if (out_head && !out_tail && !first_q) proto_err_q <= 1'b1;
                        if (out_tail) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dest_x    = dest_x_q;
    assign dest_y    = dest_y_q;
    assign out_port  = out_port_q;
    assign route_err = route_err_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit with a small XY route-compute model.
module tb_router_input_unit;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 64;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_head;
    logic              in_tail;
    logic [29:0]       dest_x;
    logic [29:0]       dest_y;
    logic [2:0]        route_port;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_head;
    logic              out_tail;
    logic [2:0]        out_port;
    logic              route_err;
    logic              proto_err;

    int n_vec;
    int n_err;

    router_input_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_head(in_head), .in_tail(in_tail),
        .dest_x(dest_x), .dest_y(dest_y), .route_port(route_port),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_head(out_head), .out_tail(out_tail), .out_port(out_port),
        .route_err(route_err), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Route-compute stand-in: fixed ports keyed on dest_x
    always_comb begin
        case (dest_x)
            30'd3:   route_port = 3'b001;
            30'd5:   route_port = 3'b010;
            30'd7:   route_port = 3'b100;
            30'd9:   route_port = 3'b110;
            default: route_port = 3'b000;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] flit(input int dx, input int dy, input int seq);
        return {4'(seq), 30'(dy), 30'(dx)};
    endfunction

    task automatic push_flit(input logic [63:0] d, input logic h, input logic t);
        int w;
        in_valid = 1'b1;
        in_data  = d;
        in_head  = h;
        in_tail  = t;
        w = 0;
        while (!in_ready && w < 50) begin
            step();
            w++;
        end
        if (w >= 50) check("push_timeout", 64'd1, 64'd0);
        step();
        in_valid = 1'b0;
        in_head  = 1'b0;
        in_tail  = 1'b0;
    endtask

    // Single-flit packet with latency, port and error-pulse checks
    task automatic send_single(input int dx, input logic [2:0] exp_port, input logic exp_rerr);
        in_valid = 1'b1;
        in_data  = flit(dx, 0, 0);
        in_head  = 1'b1;
        in_tail  = 1'b1;
        step();
        in_valid = 1'b0;
        check("lat_t1_valid", 64'(out_valid), 64'd0);
        step();
        check("lat_t2_valid", 64'(out_valid), 64'd0);
        check("lat_t2_dest_x", 64'(dest_x), 64'(dx));
        check("lat_t2_rerr", 64'(route_err), 64'd0);
        step();
        check("lat_t3_valid", 64'(out_valid), 64'd1);
        check("single_port", 64'(out_port), 64'(exp_port));
        check("single_head", 64'(out_head), 64'd1);
        check("single_tail", 64'(out_tail), 64'd1);
        check("single_rerr", 64'(route_err), 64'(exp_rerr));
        step();
        check("single_idle_valid", 64'(out_valid), 64'd0);
        check("single_rerr_clr", 64'(route_err), 64'd0);
        check("single_port_hold", 64'(out_port), 64'(exp_port));
    endtask

    int          cyc [8];
    logic [2:0]  prt [8];
    int          k;

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_head   = 1'b0;
        in_tail   = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_dest_x", 64'(dest_x), 64'd0);
        check("rst_dest_y", 64'(dest_y), 64'd0);
        check("rst_out_port", 64'(out_port), 64'd0);
        check("rst_route_err", 64'(route_err), 64'd0);
        check("rst_proto_err", 64'(proto_err), 64'd0);

        // Single-flit packet to port 001
        send_single(3, 3'b001, 1'b0);

        // Four flits against a stalled switch, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_flit(flit(5, 1, i), i == 0, i == 3);
        check("full_in_ready", 64'(in_ready), 64'd0);
        check("full_out_valid", 64'(out_valid), 64'd1);
        check("full_out_port", 64'(out_port), 64'd2);
        check("full_dest_y", 64'(dest_y), 64'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_data", out_data, flit(5, 1, i));
            check("drain_port", 64'(out_port), 64'd2);
            check("drain_tail", 64'(out_tail), 64'(i == 3));
            if (i == 0) check("drain_in_ready_0", 64'(in_ready), 64'd0);
            if (i == 1) check("drain_in_ready_1", 64'(in_ready), 64'd1);
            step();
        end
        check("drain_done_valid", 64'(out_valid), 64'd0);

        // Back-to-back packets: 3 flits to 010, 2 flits to 100
        k = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) push_flit(flit(5, 0, i), i == 0, i == 2);
                for (int i = 0; i < 2; i++) push_flit(flit(7, 0, 8 + i), i == 0, i == 1);
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    if (out_valid && out_ready && k < 8) begin
                        cyc[k] = c;
                        prt[k] = out_port;
                        k++;
                    end
                    step();
                end
            end
        join
        check("b2b_count", 64'(k), 64'd5);
        if (k == 5) begin
            check("b2b_port_a0", 64'(prt[0]), 64'd2);
            check("b2b_port_a2", 64'(prt[2]), 64'd2);
            check("b2b_port_b0", 64'(prt[3]), 64'd4);
            check("b2b_port_b1", 64'(prt[4]), 64'd4);
            check("b2b_stream_a", 64'(cyc[2] - cyc[0]), 64'd2);
            check("b2b_gap", 64'(cyc[3] - cyc[2]), 64'd3);
            check("b2b_stream_b", 64'(cyc[4] - cyc[3]), 64'd1);
        end

        // Multi-bit route result reduced to lowest bit
        send_single(9, 3'b010, 1'b1);

        // Stray body flit in IDLE is dropped
        push_flit(flit(0, 0, 0), 1'b0, 1'b0);
        check("drop_valid_t1", 64'(out_valid), 64'd0);
        step();
        check("drop_proto_err", 64'(proto_err), 64'd1);
        check("drop_valid_t2", 64'(out_valid), 64'd0);
        step();
        check("drop_proto_clr", 64'(proto_err), 64'd0);
        check("drop_empty", 64'(out_valid), 64'd0);
        send_single(3, 3'b001, 1'b0);

        // Reset with two flits of a packet buffered
        out_ready = 1'b0;
        push_flit(flit(7, 2, 0), 1'b1, 1'b0);
        push_flit(flit(7, 2, 1), 1'b0, 1'b0);
        step();
        check("prerst_valid", 64'(out_valid), 64'd1);
        check("prerst_port", 64'(out_port), 64'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'd0);
        check("midrst_port", 64'(out_port), 64'd0);
        check("midrst_dest_x", 64'(dest_x), 64'd0);
        check("midrst_dest_y", 64'(dest_y), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_proto_err", 64'(proto_err), 64'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("postrst_valid", 64'(out_valid), 64'd0);
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        send_single(5, 3'b010, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/router_input_unit.md
# router_input_unit

Per-input-port front end of the mesh router. It buffers incoming flits in a small FIFO and extracts dest_x/dest_y from each head flit into registers that drive the combinational XY route-compute stage directly downstream. It samples that stage's 3-bit port decision and holds it for the whole packet while forwarding flits to the switch with a valid/ready handshake.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DATA_W, 64: flit payload width, ≥60. The head flit carries dest_x in [29:0] and dest_y in [59:30].

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream flit valid.
- in_ready  out  1  upstream ready; equals ~full.
- in_data  in  DATA_W  flit payload.
- in_head  in  1  flit is a packet head.
- in_tail  in  1  flit is a packet tail; head and tail may both be set.
- dest_x  out  30  registered x-destination to route compute.
- dest_y  out  30  registered y-destination to route compute.
- route_port  in  3  route-compute result; combinational function of dest_x/dest_y.
- out_valid  out  1  flit valid to switch.
- out_ready  in  1  switch accepts flit.
- out_data  out  DATA_W  flit payload (FIFO head).
- out_head  out  1  flit head marker.
- out_tail  out  1  flit tail marker.
- out_port  out  3  held port decision for the current packet; 3'b000 = local eject.
- route_err  out  1  one-cycle pulse: route_port had more than one bit set.
- proto_err  out  1  one-cycle pulse: framing violation.

## Operation
- FIFO:
  - push on in_valid & in_ready; pop on out_valid & out_ready, or on a drop in IDLE.
  - No bypass: a flit pushed in cycle t is visible at the FIFO head in t+1.
  - Push and pop in the same cycle leave count unchanged.
  - Pointers wrap modulo DEPTH. count has clog2(DEPTH)+1 bits.
- FSM states: IDLE, ROUTE, ACTIVE.
  - IDLE, FIFO non-empty, head entry has head=1: load dest_x = data[29:0] and dest_y = data[59:30], then go to ROUTE.
  - IDLE, FIFO non-empty, head entry has head=0: pop and discard the entry, pulse proto_err, stay in IDLE.
  - ROUTE: sample route_port into out_port, then go to ACTIVE. If route_port has more than one bit set, keep only the lowest set bit and pulse route_err.
  - ACTIVE: out_valid = ~empty. On each accepted flit with tail=1, go to IDLE.
  - ACTIVE, a flit with head=1 and tail=0 after the first flit of the packet: forward it unchanged on the held out_port and pulse proto_err.
- out_valid is 0 in IDLE and ROUTE.
- out_port and dest_x/dest_y hold their values until the next head flit is loaded.

## Timing
- Reset (async assert, sync-safe deassert):
  - state is IDLE, FIFO is empty.
  - in_ready=1 (combinational from count=0).
  - dest_x, dest_y, out_port are 0.
  - out_valid, route_err, proto_err are 0.
  - out_data, out_head, out_tail are don't-care while out_valid=0.
- Reset mid-packet discards all buffered flits and the held port. There is no partial-packet recovery.
- Latency: a head pushed in cycle t reaches the FIFO head in t+1. dest is registered at the end of t+1, ROUTE runs in t+2, and out_valid is first asserted in t+3.
- Body flits stream back to back, one per cycle, while out_ready=1.
- Inter-packet bubble: when a tail is accepted in cycle u and the next head is already buffered, state is IDLE in u+1, ROUTE in u+2, and the head is presented in u+3.
- Full FIFO: in_ready=0. A pop in that cycle does not raise in_ready until the next cycle.
- Error pulses are registered, one cycle wide, and asserted in the cycle after the triggering event.

## Test plan
- Single-flit packet: head=tail=1, dest_x=3, dest_y=0, route model returns 3'b001. Required: out_valid in cycle t+3, out_port=3'b001, out_head=out_tail=1, state back to IDLE.
- 4-flit packet with out_ready stuck at 0 and DEPTH=4: in_ready drops after 4 pushes. Release out_ready: flits drain in 4 consecutive cycles on a constant out_port, and in_ready returns to 1 one cycle after the first pop.
- Two packets back to back, 3 flits then 2 flits, with different route_port values (3'b010 then 3'b100). Required: exactly 2 idle cycles between the tail of packet 1 and the head of packet 2 at the output, and out_port switches only at the head of packet 2.
- Route model returns 3'b110. Required: out_port=3'b010 and route_err pulses for exactly 1 cycle.
- Body flit (head=0) arrives while IDLE. Required: it is dropped, proto_err pulses, no out_valid, and the following valid packet routes normally.
- Assert rst_n low mid-packet with 2 flits buffered. Required: all outputs return to their reset values immediately, the FIFO is empty after release, and the next packet routes with normal latency.
